// File: rtl/ip_s_axis_mm2s_data_pkg.sv
// Shared definitions for the MM2S receive path: status layout,
// expected command tag and FSM encoding.
package ip_s_axis_mm2s_data_pkg;

    localparam logic [3:0] MM2S_TAG = 4'hA;

    localparam int STS_INTERR = 4;
    localparam int STS_DECERR = 5;
    localparam int STS_SLVERR = 6;
    localparam int STS_OKAY   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WAIT_STS,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic sts_bad(input logic [7:0] sts);
        return (sts[3:0] != MM2S_TAG)
            || sts[STS_INTERR]
            || sts[STS_DECERR]
            || sts[STS_SLVERR]
            || !sts[STS_OKAY];
    endfunction

endpackage

// File: rtl/ip_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags.
// Shared between the MM2S and S2MM data paths.
module ip_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/ip_s_axis_mm2s_data.sv
// MM2S receive side: buffers the DataMover data stream, checks the
// status byte and reports completion with a done pulse and sticky error.
module ip_s_axis_mm2s_data
    import ip_s_axis_mm2s_data_pkg::*;
#(
    parameter int READ_BURST_LEN       = 8,
    parameter int C_S_AXIS_TDATA_WIDTH = 128,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            uip2axi_rd_en,
    input  logic                            s_axis_mm2s_tvalid,
    output logic                            s_axis_mm2s_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_mm2s_tdata,
    input  logic                            s_axis_mm2s_tlast,
    input  logic                            s_axis_mm2s_sts_tvalid,
    output logic                            s_axis_mm2s_sts_tready,
    input  logic [7:0]                      s_axis_mm2s_sts_tdata,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] axi2uip_rd_data,
    output logic                            axi2uip_rd_valid,
    input  logic                            uip2axi_rd_ready,
    output logic                            axi2uip_rd_busy,
    output logic                            axi2uip_rd_done,
    output logic                            axi2uip_rd_err
);

    localparam int CW = $clog2(READ_BURST_LEN) + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]   pop_cnt_q, pop_cnt_d;
    logic            sts_seen_q, sts_seen_d;
    logic            err_q, err_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_dout;
    logic            beat_hs;
    logic            sts_hs;
    logic            pop;
    logic            last_pos;

    assign s_axis_mm2s_tready = (state_q == ST_RECV) && !fifo_full;
    assign s_axis_mm2s_sts_tready = !sts_seen_q
        && ((state_q == ST_RECV) || (state_q == ST_WAIT_STS));

    assign beat_hs  = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
    assign sts_hs   = s_axis_mm2s_sts_tvalid && s_axis_mm2s_sts_tready;
    assign pop      = !fifo_empty && uip2axi_rd_ready;
    assign last_pos = (beat_cnt_q == CW'(READ_BURST_LEN - 1));

    ip_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_S_AXIS_TDATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (beat_hs),
        .pop   (pop),
        .din   (s_axis_mm2s_tdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        sts_seen_d = sts_seen_q;
        err_d      = err_q;

        if (pop && (state_q != ST_IDLE) && (state_q != ST_DONE))
            pop_cnt_d = pop_cnt_q + CW'(1);

        if (sts_hs) begin
            sts_seen_d = 1'b1;
            if (sts_bad(s_axis_mm2s_sts_tdata)) err_d = 1'b1;
        end

        // Transitions look at next-cycle counts so done lands one
        // cycle after whichever of final pop or status comes last.
        unique case (state_q)
            ST_IDLE: begin
                if (uip2axi_rd_en) begin
                    beat_cnt_d = '0;
                    pop_cnt_d  = '0;
                    sts_seen_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = ST_RECV;
                end
            end
            ST_RECV: begin
                if (beat_hs) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (s_axis_mm2s_tlast != last_pos) err_d = 1'b1;
                    if (s_axis_mm2s_tlast || last_pos)
                        state_d = sts_seen_d ? ST_DRAIN : ST_WAIT_STS;
                end
            end
            ST_WAIT_STS: begin
                if (sts_seen_d)
                    state_d = (pop_cnt_d == beat_cnt_q) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop_cnt_d == beat_cnt_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            pop_cnt_q  <= '0;
            sts_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            sts_seen_q <= sts_seen_d;
            err_q      <= err_d;
        end
    end

    assign axi2uip_rd_valid = !fifo_empty;
    assign axi2uip_rd_data  = fifo_empty ? '0 : fifo_dout;
    assign axi2uip_rd_busy  = (state_q != ST_IDLE);
    assign axi2uip_rd_done  = (state_q == ST_DONE);
    assign axi2uip_rd_err   = err_q;

endmodule

// File: tb/tb_ip_s_axis_mm2s_data.sv
// Scoreboard bench for ip_s_axis_mm2s_data: expected beats and error
// flags are queued at stimulus time and checked by a separate monitor.
module tb_ip_s_axis_mm2s_data;

    localparam int W   = 128;
    localparam int RBL = 8;
    localparam int FD  = 4;

    logic         clk;
    logic         rstn;
    logic         rd_en;
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;
    logic         sts_tvalid;
    logic         sts_tready;
    logic [7:0]   sts_tdata;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic         busy;
    logic         done;
    logic         err;

    ip_s_axis_mm2s_data #(
        .READ_BURST_LEN       (RBL),
        .C_S_AXIS_TDATA_WIDTH (W),
        .FIFO_DEPTH           (FD)
    ) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .uip2axi_rd_en          (rd_en),
        .s_axis_mm2s_tvalid     (tvalid),
        .s_axis_mm2s_tready     (tready),
        .s_axis_mm2s_tdata      (tdata),
        .s_axis_mm2s_tlast      (tlast),
        .s_axis_mm2s_sts_tvalid (sts_tvalid),
        .s_axis_mm2s_sts_tready (sts_tready),
        .s_axis_mm2s_sts_tdata  (sts_tdata),
        .axi2uip_rd_data        (rd_data),
        .axi2uip_rd_valid       (rd_valid),
        .uip2axi_rd_ready       (rd_ready),
        .axi2uip_rd_busy        (busy),
        .axi2uip_rd_done        (done),
        .axi2uip_rd_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [W-1:0] bd(input int t, input int i);
        return {8'(t), 120'(i)};
    endfunction

    // Monitor: pops expected beats on every user pop, and expected
    // error flags on every done pulse.
    always @(negedge clk) begin
        if (rstn && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) fail("unexpected_pop");
            else chk("rd_data", rd_data, exp_q.pop_front());
        end
        if (rstn && done) begin
            done_cnt++;
            if (exp_err_q.size() == 0) fail("unexpected_done");
            else chk("rd_err", W'(err), W'(exp_err_q.pop_front()));
        end
    end

    task automatic arm();
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        tvalid = 1'b1;
        tdata = d;
        tlast = last;
        do begin
            @(negedge clk);
            ok = tready;
            @(posedge clk);
            n++;
        end while (!ok && n < 200);
        if (!ok) fail("beat_timeout");
        else begin
            exp_q.push_back(d);
            acc_cnt++;
        end
        #1;
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic send_sts(input logic [7:0] s);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        sts_tvalid = 1'b1;
        sts_tdata = s;
        do begin
            @(negedge clk);
            ok = sts_tready;
            @(posedge clk);
            n++;
        end while (!ok && n < 200);
        if (!ok) fail("sts_timeout");
        #1 sts_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start) fail(name);
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int t, input logic [7:0] s, input logic e);
        for (int i = 0; i < RBL; i++) send_beat(bd(t, i), i == RBL - 1);
        exp_err_q.push_back(e);
        send_sts(s);
    endtask

    initial begin
        int d0;
        int a0;
        rstn = 1'b0;
        rd_en = 1'b0;
        tvalid = 1'b0;
        tdata = '0;
        tlast = 1'b0;
        sts_tvalid = 1'b0;
        sts_tdata = '0;
        rd_ready = 1'b0;
        #12;
        chk("rst_tready", W'(tready), '0);
        chk("rst_sts_tready", W'(sts_tready), '0);
        chk("rst_valid", W'(rd_valid), '0);
        chk("rst_data", rd_data, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_err", W'(err), '0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Normal burst
        rd_ready = 1'b1;
        d0 = done_cnt;
        arm();
        chk("arm_busy", W'(busy), W'(1));
        chk("arm_tready", W'(tready), W'(1));
        burst(1, 8'h8A, 1'b0);
        wait_done("normal_done");
        chk("normal_idle_busy", W'(busy), '0);
        repeat (3) @(posedge clk);
        #1 chk("normal_done_once", W'(done_cnt - d0), W'(1));

        // Backpressure with a 4-entry FIFO
        rd_ready = 1'b0;
        d0 = done_cnt;
        a0 = acc_cnt;
        arm();
        fork
            for (int i = 0; i < RBL; i++) send_beat(bd(2, i), i == RBL - 1);
        join_none
        repeat (12) @(negedge clk);
        chk("bp_accepted", W'(acc_cnt - a0), W'(4));
        chk("bp_tready", W'(tready), '0);
        chk("bp_valid", W'(rd_valid), W'(1));
        chk("bp_head", rd_data, bd(2, 0));
        @(posedge clk);
        #1 rd_ready = 1'b1;
        exp_err_q.push_back(1'b0);
        send_sts(8'h8A);
        wait_done("bp_done");
        chk("bp_all_beats", W'(acc_cnt - a0), W'(8));
        repeat (3) @(posedge clk);
        #1 chk("bp_done_once", W'(done_cnt - d0), W'(1));

        // Slave error
        arm();
        burst(3, 8'hCA, 1'b1);
        wait_done("slverr_done");
        chk("slverr_sticky", W'(err), W'(1));

        // Early status; the arm also clears the previous error
        arm();
        chk("rearm_err_clear", W'(err), '0);
        exp_err_q.push_back(1'b0);
        send_sts(8'h8A);
        for (int i = 0; i < RBL; i++) send_beat(bd(4, i), i == RBL - 1);
        wait_done("early_sts_done");

        // Early tlast on beat 4, then a stalled sixth beat
        arm();
        for (int i = 0; i < 5; i++) send_beat(bd(5, i), i == 4);
        tvalid = 1'b1;
        tdata = bd(5, 5);
        repeat (3) begin
            @(negedge clk);
            chk("early_tlast_stall", W'(tready), '0);
        end
        @(posedge clk);
        #1;
        exp_err_q.push_back(1'b1);
        send_sts(8'h8A);
        wait_done("early_tlast_done");
        tvalid = 1'b0;
        chk("early_tlast_sticky", W'(err), W'(1));

        // Busy arm mid-transfer must not restart the beat count
        a0 = acc_cnt;
        arm();
        for (int i = 0; i < 3; i++) send_beat(bd(6, i), 1'b0);
        arm();
        for (int i = 3; i < RBL; i++) send_beat(bd(6, i), i == RBL - 1);
        exp_err_q.push_back(1'b0);
        send_sts(8'h8A);
        wait_done("busy_arm_done");
        chk("busy_arm_beats", W'(acc_cnt - a0), W'(8));

        // Reset mid-transfer
        rd_ready = 1'b0;
        arm();
        for (int i = 0; i < 3; i++) send_beat(bd(7, i), 1'b0);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", W'(rd_valid), '0);
        chk("mid_rst_data", rd_data, '0);
        chk("mid_rst_busy", W'(busy), '0);
        chk("mid_rst_tready", W'(tready), '0);
        chk("mid_rst_sts_tready", W'(sts_tready), '0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset
        rd_ready = 1'b1;
        arm();
        burst(8, 8'h8A, 1'b0);
        wait_done("recover_done");

        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_empty", W'(exp_q.size()), '0);
        chk("exp_err_empty", W'(exp_err_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ip_s_axis_mm2s_data.md
# ip_s_axis_mm2s_data

Receive-side companion to the MM2S command generator. After a read command has been issued to the AXI DataMover, this block accepts the READ_BURST_LEN-beat MM2S data stream and the 8-bit MM2S status stream. It buffers the beats in a small FIFO and delivers them to the user IP through a valid/ready port. It signals completion with a one-cycle done pulse and a sticky error flag, both checked against the command tag 4'hA.

## Interface
- READ_BURST_LEN, 8, beats per read command (>=2)
- C_S_AXIS_TDATA_WIDTH, 128, data beat width in bits
- FIFO_DEPTH, 16, beat buffer entries (power of 2, >=2)

- clk  in  1  sole clock
- rstn  in  1  asynchronous, active-low reset
- uip2axi_rd_en  in  1  same request strobe that drives the command generator; arms this block
- s_axis_mm2s_tvalid  in  1  data stream valid
- s_axis_mm2s_tready  out  1  data stream ready
- s_axis_mm2s_tdata  in  C_S_AXIS_TDATA_WIDTH  data beat
- s_axis_mm2s_tlast  in  1  last beat of the transfer
- s_axis_mm2s_sts_tvalid  in  1  status valid
- s_axis_mm2s_sts_tready  out  1  status ready
- s_axis_mm2s_sts_tdata  in  8  status byte: [3:0] tag, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY
- axi2uip_rd_data  out  C_S_AXIS_TDATA_WIDTH  FIFO head; forced to 0 when valid is low
- axi2uip_rd_valid  out  1  FIFO not empty
- uip2axi_rd_ready  in  1  user pop
- axi2uip_rd_busy  out  1  state != IDLE
- axi2uip_rd_done  out  1  one-cycle completion pulse
- axi2uip_rd_err  out  1  sticky error; cleared on next arm

## Operation
- **FSM states:** IDLE, RECV, WAIT_STS, DRAIN, DONE.
- **IDLE:**
  - Go to RECV when uip2axi_rd_en=1.
  - On arm: clear beat counter, pop counter, sts_seen and err.
- **RECV:**
  - s_axis_mm2s_tready = !fifo_full.
  - Each accepted beat is pushed into the FIFO and increments beat_cnt.
  - The transfer ends on the accepted beat where beat_cnt == READ_BURST_LEN-1 or tlast=1, whichever comes first.
  - Length error: tlast on any beat other than beat READ_BURST_LEN-1, or tlast absent on that beat. Sets err; the transfer still ends.
  - At end of transfer, go to WAIT_STS.
- **WAIT_STS:**
  - Data tready=0; extra beats are stalled, never dropped.
  - Status tready=1 whenever !sts_seen, in both RECV and WAIT_STS, so status arriving early is still captured.
  - On status capture, set err if tag != 4'hA, or any of bits [6:4] is set, or bit 7 = 0.
  - Go to DRAIN once sts_seen=1.
- **DRAIN:**
  - Wait until pop_cnt equals the number of beats received.
  - Then go to DONE.
- **DONE:** axi2uip_rd_done=1 for exactly one cycle, then IDLE.
- **FIFO:**
  - Show-ahead; a pop occurs when rd_valid && rd_ready.
  - Push and pop in the same cycle is legal at any occupancy except push-when-full, which is excluded by tready.
- **Busy arm:** uip2axi_rd_en while not in IDLE is ignored.
- **Counters:** beat_cnt and pop_cnt are each $clog2(READ_BURST_LEN)+1 bits; they never wrap within one command.

## Timing
- **Reset values:** every output is 0; FIFO pointers cleared; state = IDLE.
- **Reset mid-transfer:** FIFO contents discarded. Beats still in flight upstream are the system's responsibility; the DataMover is reset with this block.
- **Arm latency:** uip2axi_rd_en at edge N puts the block in RECV with tready=1 from cycle N+1.
- **Data latency:** a beat accepted at edge N is visible as axi2uip_rd_valid in cycle N+1.
- **Backpressure:** tready deasserts in the same cycle the FIFO becomes full (registered full flag); it reasserts the cycle after a pop.
- **Done:** the pulse occurs the cycle after the final pop edge, provided status was captured; otherwise it follows the status edge by one cycle. axi2uip_rd_err is valid during the done cycle and holds until the next arm.
- **Status vs. last beat:** status and last beat accepted in the same cycle is legal; the transition then goes directly RECV→DRAIN.

## Structure
- **Shared package:** MM2S_TAG=4'hA, status bit index constants, FSM state enum.
- **Sub-module:** ip_sync_fifo (parameters DEPTH and WIDTH; ports push, pop, din, dout, full, empty; asynchronous active-low reset). Reusable by the S2MM path.
- **This module:** FSM, counters, status check, output gating.

## Test plan
- **Normal burst:** arm; 8 beats with data 0..7, tlast on beat 7; rd_ready=1; status 8'h8A. Expect outputs 0..7 in order, a single done pulse, err=0, busy low after done.
- **Backpressure:** FIFO_DEPTH=4, rd_ready=0. Expect tready to drop after 4 beats. Raise rd_ready: all 8 beats delivered, done pulses once.
- **Slave error:** status 8'hCA. Expect done with err=1. Next arm clears err.
- **Early tlast:** tlast on beat 4 (5 beats). Expect err=1; done after 5 pops; the 6th offered beat sees tready=0.
- **Early status:** status before the first beat, then 8 beats. Expect normal completion, err=0.
- **Reset and busy arm:** rstn low after 3 beats → all outputs 0, valid=0. A second rd_en while busy has no effect on beat count.
